mac_dot_stream: RTL

- Parametrised, streaming successor to the single-lane multiply-accumulate block.
- Each accepted beat carries LANES operand pairs. The block multiplies each pair, sums the lanes, and accumulates the sum over a vector that is terminated by in_last.
- At the end of each vector it emits the result, beat count and an overflow flag through a valid/ready output. The vector accumulator then restarts from zero.
- Used as the dot-product engine in datapaths fed by streaming sources.

---
 rtl/mac_pkg.sv | 49 ++++
 rtl/mac_dot_stream_if.sv | 33 +++
 rtl/mac_lane_mult.sv | 41 ++++
 rtl/mac_dot_stream.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mac_pkg.sv
// Shared definitions for the mac_dot_stream dot-product engine: width helpers,
// the per-stage sideband record and saturation limits derived from ACC_W.
package mac_pkg;

  // Upper bound on ACC_W that the saturation-limit helpers can describe.
  localparam int MAX_ACC_W = 128;

  // Control that travels alongside each beat through the pipeline.
  typedef struct packed {
    logic valid;
    logic last;
    logic signed_mode;
  } side_t;

  // Full-precision width of one DATA_W x DATA_W product.
  function automatic int prod_w(input int data_w);
    return 2 * data_w;
  endfunction

  // Smallest accumulator that holds a lane sum without overflow.
  function automatic int min_acc_w(input int data_w, input int lanes);
    return 2 * data_w + $clog2(lanes);
  endfunction

  // Largest unsigned value: all ACC_W bits set.
  function automatic logic [MAX_ACC_W-1:0] sat_umax(input int acc_w);
    logic [MAX_ACC_W-1:0] r;
    r = '0;
    for (int i = 0; i < acc_w; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Largest positive two's-complement value at ACC_W bits.
  function automatic logic [MAX_ACC_W-1:0] sat_smax(input int acc_w);
    logic [MAX_ACC_W-1:0] r;
    r = '0;
    for (int i = 0; i < acc_w - 1; i++) r[i] = 1'b1;
    return r;
  endfunction

  // Most negative two's-complement value at ACC_W bits.
  function automatic logic [MAX_ACC_W-1:0] sat_smin(input int acc_w);
    logic [MAX_ACC_W-1:0] r;
    r = '0;
    r[acc_w-1] = 1'b1;
    return r;
  endfunction

endpackage

// File: rtl/mac_dot_stream_if.sv
// Beat input / result output bundle of mac_dot_stream. The master side is the
// producer of beats and consumer of results; the slave side is the engine.
interface mac_dot_stream_if #(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) ();

  logic                    clear;
  logic                    in_valid;
  logic                    in_ready;
  logic [LANES*DATA_W-1:0] in_a;
  logic [LANES*DATA_W-1:0] in_b;
  logic                    in_last;
  logic                    signed_mode;
  logic                    out_valid;
  logic                    out_ready;
  logic [ACC_W-1:0]        out_data;
  logic [CNT_W-1:0]        out_count;
  logic                    out_overflow;

  modport master (
    output clear, in_valid, in_a, in_b, in_last, signed_mode, out_ready,
    input  in_ready, out_valid, out_data, out_count, out_overflow
  );

  modport slave (
    input  clear, in_valid, in_a, in_b, in_last, signed_mode, out_ready,
    output in_ready, out_valid, out_data, out_count, out_overflow
  );

endinterface

// File: rtl/mac_lane_mult.sv
// One operand lane: DATA_W x DATA_W multiply, signed or unsigned per beat,
// with a registered 2*DATA_W product that holds while en is low.
module mac_lane_mult #(
  parameter int DATA_W = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                en,
  input  logic [DATA_W-1:0]   a,
  input  logic [DATA_W-1:0]   b,
  input  logic                signed_mode,
  output logic [2*DATA_W-1:0] p
);

  logic [2*DATA_W-1:0] a_ext;
  logic [2*DATA_W-1:0] b_ext;
  logic [2*DATA_W-1:0] p_d;
  logic [2*DATA_W-1:0] p_q;

  // Extend both operands per mode, then keep the low 2*DATA_W product bits,
  // which are exact for either signedness.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it
    // unassigned, which would otherwise infer a latch.
    p_d   = p_q;
    a_ext = {{DATA_W{signed_mode & a[DATA_W-1]}}, a};
    b_ext = {{DATA_W{signed_mode & b[DATA_W-1]}}, b};
    if (en) p_d = a_ext * b_ext;
  end

  // Product register.
  always_ff @(posedge clk or posedge rst) begin
    // NOTE: sequential state uses non-blocking assignments so every flop
    // samples pre-edge values regardless of block ordering.
    if (rst) p_q <= '0;
    else     p_q <= p_d;
  end

  assign p = p_q;

endmodule

// File: rtl/mac_dot_stream.sv
// Streaming dot-product engine: LANES products per beat, summed and
// accumulated over a vector terminated by in_last, result emitted through a
// valid/ready output with a saturating beat count and sticky overflow flag.
// Optional MAC_DOT_SATURATE_EN: clamp the accumulator on overflow instead of
// wrapping.
module mac_dot_stream
  import mac_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int LANES  = 2,
  parameter int ACC_W  = 40,
  parameter int CNT_W  = 8
) (
  input  logic              clk,
  input  logic              rst,
  mac_dot_stream_if.slave   bus
);

  localparam int PW = prod_w(DATA_W);

  if (ACC_W < min_acc_w(DATA_W, LANES)) begin : g_acc_w_check
    $error("mac_dot_stream: ACC_W must be at least 2*DATA_W + clog2(LANES)");
  end

`ifdef MAC_DOT_SATURATE_EN
  localparam logic [MAX_ACC_W-1:0] UMAX_W = sat_umax(ACC_W);
  localparam logic [MAX_ACC_W-1:0] SMAX_W = sat_smax(ACC_W);
  localparam logic [MAX_ACC_W-1:0] SMIN_W = sat_smin(ACC_W);
  localparam logic [ACC_W-1:0]     UMAX   = UMAX_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0]     SMAX   = SMAX_W[ACC_W-1:0];
  localparam logic [ACC_W-1:0]     SMIN   = SMIN_W[ACC_W-1:0];
`endif

  side_t                   s1_d, s1_q, s2_d, s2_q, s3_d, s3_q;
  logic [LANES*DATA_W-1:0] a_d, a_q, b_d, b_q;
  logic [ACC_W-1:0]        sum_d, sum_q, acc_d, acc_q;
  logic [CNT_W-1:0]        cnt_d, cnt_q;
  logic                    ovf_d, ovf_q;
  logic                    out_valid_d, out_valid_q;
  logic [ACC_W-1:0]        out_data_d, out_data_q;
  logic [CNT_W-1:0]        out_count_d, out_count_q;
  logic                    out_ovf_d, out_ovf_q;

  logic [PW-1:0]           prod [LANES];
  logic                    stall;
  logic                    advance;
  logic [ACC_W-1:0]        lane_sum;
  logic [ACC_W:0]          wide_add;
  logic [ACC_W-1:0]        acc_next;
  logic                    ovf_now;
  logic [CNT_W-1:0]        cnt_inc;

  // A held result blocks the whole pipeline; clear also blocks acceptance.
  assign stall        = out_valid_q & ~bus.out_ready;
  assign advance      = ~stall & ~bus.clear;
  assign bus.in_ready = ~stall & ~bus.clear;

  // S2: one registered multiplier per lane, fed from the S1 operand registers.
  for (genvar l = 0; l < LANES; l++) begin : g_lane
    mac_lane_mult #(.DATA_W(DATA_W)) u_mult (
      .clk         (clk),
      .rst         (rst),
      .en          (advance),
      .a           (a_q[l*DATA_W +: DATA_W]),
      .b           (b_q[l*DATA_W +: DATA_W]),
      .signed_mode (s1_q.signed_mode),
      .p           (prod[l])
    );
  end

  // Lane sum at accumulator width, extended per the beat's own mode.
  always_comb begin
    lane_sum = '0;
    for (int l = 0; l < LANES; l++) begin
      if (s2_q.signed_mode) lane_sum = lane_sum + ACC_W'($signed(prod[l]));
      else                  lane_sum = lane_sum + ACC_W'(prod[l]);
    end
  end

  // Accumulator update, overflow detection and saturating beat count.
  always_comb begin
    wide_add = {1'b0, acc_q} + {1'b0, sum_q};
    if (s3_q.signed_mode)
      ovf_now = (acc_q[ACC_W-1] == sum_q[ACC_W-1]) &&
                (wide_add[ACC_W-1] != acc_q[ACC_W-1]);
    else
      ovf_now = wide_add[ACC_W];
`ifdef MAC_DOT_SATURATE_EN
    // Both addends share a sign on signed overflow, so acc's sign gives the
    // direction of the clamp.
    if (!ovf_now)              acc_next = wide_add[ACC_W-1:0];
    else if (!s3_q.signed_mode) acc_next = UMAX;
    else if (acc_q[ACC_W-1])   acc_next = SMIN;
    else                       acc_next = SMAX;
`else
    acc_next = wide_add[ACC_W-1:0];
`endif
    cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  end

  // Next state for all pipeline, accumulator and output registers.
  always_comb begin
    s1_d        = s1_q;
    s2_d        = s2_q;
    s3_d        = s3_q;
    a_d         = a_q;
    b_d         = b_q;
    sum_d       = sum_q;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    ovf_d       = ovf_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_count_d = out_count_q;
    out_ovf_d   = out_ovf_q;
    if (bus.clear) begin
      s1_d.valid  = 1'b0;
      s2_d.valid  = 1'b0;
      s3_d.valid  = 1'b0;
      acc_d       = '0;
      cnt_d       = '0;
      ovf_d       = 1'b0;
      out_valid_d = 1'b0;
    end else if (advance) begin
      s1_d  = '{valid: bus.in_valid, last: bus.in_last, signed_mode: bus.signed_mode};
      a_d   = bus.in_a;
      b_d   = bus.in_b;
      s2_d  = s1_q;
      s3_d  = s2_q;
      sum_d = lane_sum;
      // Not stalled, so any presented result is consumed this edge.
      out_valid_d = 1'b0;
      if (s3_q.valid) begin
        if (s3_q.last) begin
          out_valid_d = 1'b1;
          out_data_d  = acc_next;
          out_count_d = cnt_inc;
          out_ovf_d   = ovf_q | ovf_now;
          acc_d       = '0;
          cnt_d       = '0;
          ovf_d       = 1'b0;
        end else begin
          acc_d = acc_next;
          cnt_d = cnt_inc;
          ovf_d = ovf_q | ovf_now;
        end
      end
    end
  end

  // State registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_q        <= '0;
      s2_q        <= '0;
      s3_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      sum_q       <= '0;
      acc_q       <= '0;
      cnt_q       <= '0;
      ovf_q       <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_count_q <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      s1_q        <= s1_d;
      s2_q        <= s2_d;
      s3_q        <= s3_d;
      a_q         <= a_d;
      b_q         <= b_d;
      sum_q       <= sum_d;
      acc_q       <= acc_d;
      cnt_q       <= cnt_d;
      ovf_q       <= ovf_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_count_q <= out_count_d;
      out_ovf_q   <= out_ovf_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_data     = out_data_q;
  assign bus.out_count    = out_count_q;
  assign bus.out_overflow = out_ovf_q;

endmodule
